// File: rtl/ring_sequencer.sv
// ring_sequencer
// ----------------------------------------------------------------------------
// WIDTH-bit shift-register sequencer used to drive phase/slot selection for
// time-multiplexed logic. It has two modes:
//   mode 0 : one-hot ring, period WIDTH
//   mode 1 : Johnson (twisted ring), period 2*WIDTH
// The mode is captured into mode_q only on rst or load. Changing the mode
// input at any other time has no effect.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst      : synchronous, active-high reset (highest priority)
//   en       : advance one step this cycle
//   dir      : 0 = shift toward bit 0 (step up), 1 = toward bit WIDTH-1 (step down)
//   mode     : 0 = ring, 1 = Johnson; sampled on rst or load only
//   load     : synchronous load of load_val (below rst, above en)
//   load_val : pattern for load; not checked, so illegal patterns are accepted
//   count    : current pattern (registered)
//   step     : step index since the last rst/load, modulo the period (registered)
//   wrap     : one-cycle pulse, high in the cycle step shows its wrapped value
//   err      : count is illegal for mode_q (decoded from registers)
//
// Control priority is rst > load > en. With none of them asserted, every
// register holds and wrap returns to 0. The dir input may change on any cycle,
// so no idle cycle is needed when the direction reverses.
// ----------------------------------------------------------------------------
module ring_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic [STEP_W-1:0] step,
    output logic              wrap,
    output logic              err
);

    // Last legal step index for each mode (PERIOD-1).
    localparam logic [STEP_W-1:0] RING_LAST = STEP_W'(WIDTH - 1);
    localparam logic [STEP_W-1:0] JOHN_LAST = STEP_W'(2 * WIDTH - 1);

    // Ring mode resets to the MSB set, so the first dir=0 advance walks toward bit 0.
    localparam logic [WIDTH-1:0] RING_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    logic              mode_q;
    logic [WIDTH-1:0]  count_d;
    logic [STEP_W-1:0] step_d;
    logic              wrap_d;
    logic              mode_d;
    logic [STEP_W-1:0] step_last;
    logic [WIDTH-1:0]  shifted;

    // The bit that re-enters at the shift end is inverted in Johnson mode.
    logic              feed_dn;
    logic              feed_up;

    assign step_last = mode_q ? JOHN_LAST : RING_LAST;
    assign feed_dn   = mode_q ? ~count[0]       : count[0];
    assign feed_up   = mode_q ? ~count[WIDTH-1] : count[WIDTH-1];

    always_comb begin
        shifted = count;
        if (dir == 1'b0) begin
            shifted = {feed_dn, count[WIDTH-1:1]};
        end else begin
            shifted = {count[WIDTH-2:0], feed_up};
        end
    end

    // Next-state selection, following the rst > load > en priority.
    always_comb begin
        count_d = count;
        step_d  = step;
        wrap_d  = 1'b0;
        mode_d  = mode_q;
        if (rst) begin
            mode_d  = mode;
            count_d = mode ? '0 : RING_INIT;
            step_d  = '0;
        end else if (load) begin
            mode_d  = mode;
            count_d = load_val;
            step_d  = '0;
        end else if (en) begin
            count_d = shifted;
            if (dir == 1'b0) begin
                if (step == step_last) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step + 1'b1;
                end
            end else begin
                if (step == '0) begin
                    step_d = step_last;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        count  <= count_d;
        step   <= step_d;
        wrap   <= wrap_d;
    end

    // Legality decode.
    // In ring mode the pattern is legal when exactly one bit is set. In
    // Johnson mode a legal pattern is one run of ones next to one run of
    // zeros, so it has at most one adjacent-bit transition. The decode does
    // not gate advancing. An illegal ring pattern stays illegal under
    // rotation, so err holds until the next rst or a legal load.
    int ones;
    int trans;

    always_comb begin
        ones  = 0;
        trans = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (count[i]) ones = ones + 1;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (count[i] != count[i+1]) trans = trans + 1;
        end
    end

    assign err = mode_q ? (trans > 1) : (ones != 1);

endmodule

// File: tb/tb_ring_sequencer.sv
// Testbench for ring_sequencer (WIDTH=4, STEP_W=3).
// A reference model tracks the pattern as an integer and uses arithmetic
// rotation to advance it. It tracks the step as an integer modulo the period.
// Each cycle the model pushes the outputs it expects into exp_q, and the
// bench compares them after the edge. Directed test-plan sequences add checks
// against literal constants. A randomized phase follows them.
module tb_ring_sequencer;

  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic [SW-1:0] step;
  logic          wrap;
  logic          err;

  int n_cmp;
  int n_bad;

  // Packed expectation: {err, wrap, step, count}
  logic [W+SW+1:0] exp_q[$];

  // Model state
  int m_mode;
  int m_count;
  int m_step;
  int m_wrap;

  ring_sequencer #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(count), .step(step), .wrap(wrap), .err(err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int popc(input int v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int model_err(input int md, input int c);
    if (md == 0) return (popc(c) != 1) ? 1 : 0;
    // adjacent transitions across bits 0..W-2
    return (popc((c ^ (c >> 1)) & ((1 << (W - 1)) - 1)) > 1) ? 1 : 0;
  endfunction

  task automatic model_update(input logic r, input logic l, input logic e,
                              input logic d, input logic md, input logic [W-1:0] lv);
    int period;
    int msk;
    int in_bit;
    msk = (1 << W) - 1;
    if (r) begin
      m_mode  = int'(md);
      m_count = md ? 0 : (1 << (W - 1));
      m_step  = 0;
      m_wrap  = 0;
    end else if (l) begin
      m_mode  = int'(md);
      m_count = int'(lv);
      m_step  = 0;
      m_wrap  = 0;
    end else if (e) begin
      period = (m_mode != 0) ? 2 * W : W;
      if (!d) begin
        in_bit  = m_count & 1;
        if (m_mode != 0) in_bit = 1 - in_bit;
        m_count = ((m_count >> 1) | (in_bit << (W - 1))) & msk;
        m_wrap  = (m_step == period - 1) ? 1 : 0;
        m_step  = (m_step + 1) % period;
      end else begin
        in_bit  = (m_count >> (W - 1)) & 1;
        if (m_mode != 0) in_bit = 1 - in_bit;
        m_count = ((m_count << 1) | in_bit) & msk;
        m_wrap  = (m_step == 0) ? 1 : 0;
        m_step  = (m_step + period - 1) % period;
      end
    end else begin
      m_wrap = 0;
    end
    exp_q.push_back({model_err(m_mode, m_count) != 0, m_wrap != 0,
                     SW'(m_step), W'(m_count)});
  endtask

  // Driver: one clock cycle with the given controls, then score the outputs.
  task automatic cyc(input logic r, input logic l, input logic e, input logic d,
                     input logic md, input logic [W-1:0] lv);
    logic [W+SW+1:0] ex;
    rst = r; load = l; en = e; dir = d; mode = md; load_val = lv;
    @(posedge clk);
    model_update(r, l, e, d, md, lv);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      check("count", 32'(count), 32'(ex[W-1:0]));
      check("step",  32'(step),  32'(ex[W+SW-1:W]));
      check("wrap",  32'(wrap),  32'(ex[W+SW]));
      check("err",   32'(err),   32'(ex[W+SW+1]));
    end
  endtask

  logic [W-1:0] ring_seq [5];
  logic [W-1:0] john_seq [9];

  initial begin
    n_cmp = 0; n_bad = 0;
    m_mode = 0; m_count = 0; m_step = 0; m_wrap = 0;
    rst = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load_val = '0;
    ring_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    john_seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    @(negedge clk);

    // Ring reset and a full forward lap
    cyc(1, 0, 0, 0, 0, '0);
    check("rst_ring_count", 32'(count), 32'(4'b1000));
    check("rst_ring_step", 32'(step), 32'd0);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, '0);
      check("ring_fwd_count", 32'(count), 32'(ring_seq[i]));
      check("ring_fwd_wrap", 32'(wrap), (i == 4) ? 32'd1 : 32'd0);
      check("ring_fwd_err", 32'(err), 32'd0);
    end

    // Johnson reset and a full forward lap
    cyc(1, 0, 0, 0, 1, '0);
    check("rst_john_count", 32'(count), 32'(4'b0000));
    for (int i = 1; i < 9; i++) begin
      cyc(0, 0, 1, 0, 1, '0);
      check("john_fwd_count", 32'(count), 32'(john_seq[i]));
      check("john_fwd_step", 32'(step), 32'(i % 8));
      check("john_fwd_wrap", 32'(wrap), (i == 8) ? 32'd1 : 32'd0);
    end

    // Ring reversal at 0010 / step 2
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 1, 0, 0, '0);
    check("rev_start", 32'(count), 32'(4'b0010));
    cyc(0, 0, 1, 1, 0, '0);
    check("rev1_count", 32'(count), 32'(4'b0100));
    cyc(0, 0, 1, 1, 0, '0);
    check("rev2_count", 32'(count), 32'(4'b1000));
    cyc(0, 0, 1, 1, 0, '0);
    check("rev3_count", 32'(count), 32'(4'b0001));
    check("rev3_step", 32'(step), 32'd3);
    check("rev3_wrap", 32'(wrap), 32'd1);

    // Hold, then load over en, then rst over load
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, '0);
      check("hold_count", 32'(count), 32'(4'b0001));
      check("hold_wrap", 32'(wrap), 32'd0);
    end
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, 0, 4'b0001);
    check("load_count", 32'(count), 32'(4'b0001));
    check("load_step", 32'(step), 32'd0);
    cyc(1, 1, 1, 0, 0, 4'b0110);
    check("rst_over_load", 32'(count), 32'(4'b1000));

    // Illegal patterns
    cyc(0, 1, 0, 0, 0, 4'b0110);
    check("ill_ring_err", 32'(err), 32'd1);
    cyc(0, 0, 1, 0, 0, '0);
    check("ill_ring_rot", 32'(count), 32'(4'b0011));
    check("ill_ring_err2", 32'(err), 32'd1);
    cyc(0, 1, 0, 0, 0, 4'b0100);
    check("legal_load_err", 32'(err), 32'd0);
    cyc(0, 1, 0, 0, 1, 4'b0101);
    check("ill_john_err", 32'(err), 32'd1);

    // The mode input is ignored unless rst or load is asserted
    cyc(1, 0, 0, 0, 0, '0);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 1, 0, 1, '0);
      check("mode_ignored", 32'(count), 32'(ring_seq[i]));
    end
    cyc(0, 1, 0, 0, 1, 4'b0000);
    for (int i = 1; i < 9; i++) begin
      cyc(0, 0, 1, 0, 1, '0);
      check("john_after_load", 32'(count), 32'(john_seq[i]));
    end

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/ring_sequencer.md
Name: ring_sequencer

Overview:
Parametrised successor to the team's fixed 4-bit ring counter. It provides a WIDTH-bit shift-register sequencer with two modes: one-hot ring, and Johnson (twisted ring, period 2*WIDTH). It adds enable, direction control, synchronous load, a step index, a wrap pulse and an illegal-state flag. It drives phase and slot selection for downstream time-multiplexed logic.

Parameters:
WIDTH, 4, sequencer width in bits; legal range is 2 or more.
STEP_W, 3, step index width; must be at least clog2(2*WIDTH).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  advance one step this cycle.
dir  input  1  direction: 0 = shift toward bit 0 (step up), 1 = shift toward bit WIDTH-1 (step down).
mode  input  1  mode: 0 = ring, 1 = Johnson. Latched only on rst or load.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  pattern for load.
count  output  WIDTH  current pattern (registered).
step  output  STEP_W  step index since the last rst/load, modulo PERIOD (registered).
wrap  output  1  one-cycle pulse when step wraps (registered).
err  output  1  count is illegal for the latched mode (decoded from registers, no added latency).

Behaviour:
- Priority: rst > load > en. With none of these asserted, all registers hold and wrap=0.
- Internal mode_q is captured from mode on rst or load and used for all operations.
- PERIOD = WIDTH when mode_q=0, and 2*WIDTH when mode_q=1.
- Reset (rst=1 at edge):
  - mode_q <= mode.
  - count <= 1<<(WIDTH-1) in ring mode; count <= 0 in Johnson mode.
  - step <= 0, wrap <= 0.
- Load (load=1, rst=0):
  - count <= load_val, mode_q <= mode, step <= 0, wrap <= 0.
  - load_val is not checked; an illegal pattern is accepted.
- Advance (en=1, no rst/load), ring mode:
  - dir=0: count <= {count[0], count[W-1:1]}.
  - dir=1: count <= {count[W-2:0], count[W-1]}.
- Advance, Johnson mode:
  - dir=0: count <= {~count[0], count[W-1:1]}.
  - dir=1: count <= {count[W-2:0], ~count[W-1]}.
- Step on advance:
  - dir=0: step <= (step==PERIOD-1) ? 0 : step+1, and wrap <= 1 exactly when step was PERIOD-1.
  - dir=1: step <= (step==0) ? PERIOD-1 : step-1, and wrap <= 1 exactly when step was 0.
  - Otherwise wrap <= 0. wrap therefore goes high in the same cycle that step shows the wrapped value.
- dir may change on any cycle and takes effect on that edge. No idle cycle is needed on reversal.
- Changing mode without rst/load has no effect on count, step or mode_q.
- err (combinational from count and mode_q):
  - Ring mode: err=1 when popcount(count) != 1.
  - Johnson mode: err=1 when the number of adjacent-bit transitions (count[i] != count[i+1], i = 0..W-2) exceeds 1.
  - An illegal ring pattern stays illegal under rotation, so err stays high until the next rst or a legal load.
- err does not block advancing. step continues to count, and wrap continues to pulse normally while err=1.

Test Plan:
- WIDTH=4, rst with mode=0, then en=1, dir=0 → count 1000,0100,0010,0001,1000; step 0,1,2,3,0; wrap=1 only in the cycle step returns to 0; err=0 throughout.
- rst with mode=1, then en=1, dir=0 for 8 cycles → count 0000,1000,1100,1110,1111,0111,0011,0001,0000; step 0..7 then 0 with wrap=1; err=0.
- Ring mode at count=0010/step=2, set dir=1 → 0100/step1, 1000/step0, then 0001/step3 with wrap=1.
- en=0 for 3 cycles → count/step hold, wrap=0. load=1 with en=1 and load_val=0001 → count=0001, step=0. rst=1 with load=1 → reset values win.
- Ring mode, load 0110 → err=1; advance gives 0011, err stays 1; load 0100 → err=0. Johnson mode, load 0101 → err=1.
- Ring mode running, toggle mode to 1 without rst/load → ring sequence and PERIOD=4 unchanged. Then load 0000 with mode=1 → Johnson sequence, PERIOD=8.
